tug_of_war_ctrl: RTL and testbench

- Game sequencer for the tug-of-war playfield: center light, N-1 side lights, two player keys.
- Conditions raw player keys into one-cycle press pulses for the light chain. Light modules consume these as their L/R inputs.
- Detects round wins from the edge lights and keeps per-player scores.
- Issues next_round to re-centre the field after each point, and ends the game at max score.

---
 rtl/tug_of_war_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_tug_of_war_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tug_of_war_ctrl.sv
// Tug-of-war game sequencer: key conditioning, point detection, scoring and round/hold control.
// Optional CPU right player (LFSR driven) is compiled in with `define TUG_CPU_PLAYER_EN.
module tug_of_war_ctrl #(
    parameter int unsigned N_LIGHTS    = 9,
    parameter int unsigned SCORE_W     = 3,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter logic [7:0]  CPU_THRESH  = 8'd200
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_l,
    input  logic               key_r,
    input  logic               edge_l_on,
    input  logic               edge_r_on,
    output logic               press_l,
    output logic               press_r,
    output logic               next_round,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               game_over,
    output logic [1:0]         winner
);

    localparam int unsigned        CntW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CntW-1:0]    HoldLoad = CntW'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] ScoreMax = {SCORE_W{1'b1}};

    if (N_LIGHTS < 3 || (N_LIGHTS % 2) == 0 || HOLD_CYCLES < 1) begin : gen_bad_cfg
        $error("tug_of_war_ctrl: N_LIGHTS must be odd and >= 3, HOLD_CYCLES >= 1");
    end

    typedef enum logic [1:0] {StIdle, StPlay, StHold, StOver} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d; // bit0 left, bit1 right
    logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic               press_l_q, press_l_d, press_r_q, press_r_d;
    logic               next_round_q, next_round_d;
    logic               game_over_q, game_over_d;
    logic [1:0]         winner_q, winner_d;
    logic               rise_l, rise_r, valid_l, valid_r;

    // Sync/prev flops reset high so a key held through reset never looks like a fresh press.
    always_comb begin
        sync1_d = {key_r, key_l};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    assign rise_l = sync2_q[0] & ~prev_q[0];

`ifdef TUG_CPU_PLAYER_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic       cpu_rise_q, cpu_rise_d;

    always_comb begin
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        cpu_rise_d = (state_q == StPlay) && (lfsr_q > CPU_THRESH) && !cpu_rise_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q     <= 8'hA5;
            cpu_rise_q <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            cpu_rise_q <= cpu_rise_d;
        end
    end

    assign rise_r = cpu_rise_d;
`else
    assign rise_r = sync2_q[1] & ~prev_q[1];
`endif

    // Simultaneous rises cancel each other.
    assign valid_l = rise_l & ~rise_r;
    assign valid_r = rise_r & ~rise_l;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        score_l_d    = score_l_q;
        score_r_d    = score_r_q;
        press_l_d    = 1'b0;
        press_r_d    = 1'b0;
        next_round_d = 1'b0;
        game_over_d  = game_over_q;
        winner_d     = winner_q;

        unique case (state_q)
            StIdle: begin
                state_d      = StPlay;
                next_round_d = 1'b1;
            end
            StPlay: begin
                press_l_d = valid_l;
                press_r_d = valid_r;
                if (valid_l && edge_l_on) begin
                    score_l_d = score_l_q + 1'b1;
                    if (score_l_d == ScoreMax) begin
                        state_d     = StOver;
                        game_over_d = 1'b1;
                        winner_d    = 2'b01;
                    end else begin
                        state_d      = StHold;
                        cnt_d        = HoldLoad;
                        next_round_d = (HoldLoad == '0);
                    end
                end else if (valid_r && edge_r_on) begin
                    score_r_d = score_r_q + 1'b1;
                    if (score_r_d == ScoreMax) begin
                        state_d     = StOver;
                        game_over_d = 1'b1;
                        winner_d    = 2'b10;
                    end else begin
                        state_d      = StHold;
                        cnt_d        = HoldLoad;
                        next_round_d = (HoldLoad == '0);
                    end
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d = StPlay;
                end else begin
                    cnt_d        = cnt_q - 1'b1;
                    // Register the pulse so it lines up with the final hold cycle.
                    next_round_d = (cnt_d == '0);
                end
            end
            StOver: begin
                state_d = StOver;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            sync1_q      <= 2'b11;
            sync2_q      <= 2'b11;
            prev_q       <= 2'b11;
            score_l_q    <= '0;
            score_r_q    <= '0;
            press_l_q    <= 1'b0;
            press_r_q    <= 1'b0;
            next_round_q <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            press_l_q    <= press_l_d;
            press_r_q    <= press_r_d;
            next_round_q <= next_round_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
        end
    end

    assign press_l    = press_l_q;
    assign press_r    = press_r_q;
    assign next_round = next_round_q;
    assign score_l    = score_l_q;
    assign score_r    = score_r_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// Self-checking bench for tug_of_war_ctrl: directed game scenarios plus random key/edge traffic
// checked every cycle against a behavioural game model.
module tb_tug_of_war_ctrl;

    localparam int unsigned SW   = 3;
    localparam int unsigned HOLD = 8;
    localparam int          MAXS = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          key_l = 1'b0, key_r = 1'b0, edge_l_on = 1'b0, edge_r_on = 1'b0;
    logic          press_l, press_r, next_round, game_over;
    logic [SW-1:0] score_l, score_r;
    logic [1:0]    winner;

    always #5 clk = ~clk;

    tug_of_war_ctrl #(
        .N_LIGHTS   (9),
        .SCORE_W    (SW),
        .HOLD_CYCLES(HOLD),
        .CPU_THRESH (8'd200)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .key_l     (key_l),
        .key_r     (key_r),
        .edge_l_on (edge_l_on),
        .edge_r_on (edge_r_on),
        .press_l   (press_l),
        .press_r   (press_r),
        .next_round(next_round),
        .score_l   (score_l),
        .score_r   (score_r),
        .game_over (game_over),
        .winner    (winner)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: last three key samples per player (bit0 newest) and the game situation.
    logic [2:0] hl, hr;
    int         m_mode;      // 0 just reset, 1 playing, 2 frozen after point, 3 finished
    int         m_hold_left; // frozen cycles still to come, counting the current one
    int         m_sl, m_sr, m_win;
    bit         m_pl, m_pr, m_nr, m_go;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("press_l", 32'(press_l), 32'(m_pl));
        check("press_r", 32'(press_r), 32'(m_pr));
        check("next_round", 32'(next_round), 32'(m_nr));
        check("score_l", 32'(score_l), 32'(m_sl));
        check("score_r", 32'(score_r), 32'(m_sr));
        check("game_over", 32'(game_over), 32'(m_go));
        check("winner", 32'(winner), 32'(m_win));
    endtask

    task automatic model_reset();
        hl = 3'b111;
        hr = 3'b111;
        m_mode = 0;
        m_hold_left = 0;
        m_sl = 0; m_sr = 0; m_win = 0;
        m_pl = 0; m_pr = 0; m_nr = 0; m_go = 0;
    endtask

    task automatic score_point(input int side);
        int s;
        if (side == 1) begin
            m_sl++;
            s = m_sl;
        end else begin
            m_sr++;
            s = m_sr;
        end
        if (s == MAXS) begin
            m_mode = 3;
            m_go = 1;
            m_win = side;
        end else begin
            m_mode = 2;
            m_hold_left = HOLD;
            m_nr = (HOLD == 1);
        end
    endtask

    // Called at a rising edge: press seen after this edge comes from the sample two edges ago
    // rising over the one three edges ago.
    task automatic model_edge();
        bit rl, rr, vl, vr;
        rl = hl[1] && !hl[2];
        rr = hr[1] && !hr[2];
        hl = {hl[1:0], key_l};
        hr = {hr[1:0], key_r};
        m_pl = 0; m_pr = 0; m_nr = 0;
        case (m_mode)
            0: begin
                m_mode = 1;
                m_nr = 1;
            end
            1: begin
                vl = rl && !rr;
                vr = rr && !rl;
                m_pl = vl;
                m_pr = vr;
                if (vl && edge_l_on) score_point(1);
                else if (vr && edge_r_on) score_point(2);
            end
            2: begin
                m_hold_left--;
                if (m_hold_left == 0) m_mode = 1;
                else m_nr = (m_hold_left == 1);
            end
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asserts reset between edges, checks the outputs clear at once, holds it, then releases.
    task automatic do_reset(input int n);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_all();
        end
        reset = 1'b1;
    endtask

    initial begin
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;

        // Reset release: one next_round pulse, then play.
        steps(4);

        // Held left key, no edge light: a single press.
        key_l = 1'b1;
        steps(20);
        key_l = 1'b0;
        steps(4);

        // Simultaneous rises cancel.
        key_l = 1'b1;
        key_r = 1'b1;
        steps(6);
        key_l = 1'b0;
        key_r = 1'b0;
        steps(4);

        // Left point, then hold with the right key toggling.
        edge_l_on = 1'b1;
        key_l = 1'b1;
        steps(3);
        key_l = 1'b0;
        edge_l_on = 1'b0;
        for (int i = 0; i < 12; i++) begin
            key_r = ~key_r;
            step();
        end
        key_r = 1'b0;
        steps(4);

        // Left wins until the game ends, then keys keep coming.
        edge_l_on = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if (i % 2 == 0) key_l = ~key_l;
            if (i % 3 == 0) key_r = ~key_r;
            step();
        end
        check("score_l_final", 32'(score_l), 32'(MAXS));
        check("winner_final", 32'(winner), 32'd1);
        edge_l_on = 1'b0;
        key_l = 1'b0;
        key_r = 1'b0;
        do_reset(2);
        steps(4);

        // Reset in the middle of a hold with key_r held through it.
        edge_r_on = 1'b1;
        key_r = 1'b1;
        steps(6);
        edge_r_on = 1'b0;
        check("in_hold_score_r", 32'(score_r), 32'd1);
        do_reset(3);
        steps(8);
        key_r = 1'b0;
        steps(4);

        // Random traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) key_l = ~key_l;
            if ($urandom_range(0, 3) == 0) key_r = ~key_r;
            edge_l_on = ($urandom_range(0, 2) == 0);
            edge_r_on = ($urandom_range(0, 2) == 0);
            step();
            if ((m_mode == 3 && $urandom_range(0, 15) == 0) || $urandom_range(0, 499) == 0)
                do_reset($urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
